// File: rtl/vending_machine.sv
// Single-product coin vending controller: price Rs 3, accepts Rs 1 / Rs 2 coins.
// Mealy decision logic on (credit state, coin) with every output registered.
module vending_machine (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in,
  output logic       out,
  output logic [1:0] change
);

  typedef enum logic [1:0] {
    S0    = 2'b00,
    S1    = 2'b01,
    S2    = 2'b10,
    S_BAD = 2'b11
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;

  localparam logic [1:0] RS_0 = 2'd0;
  localparam logic [1:0] RS_1 = 2'd1;
  localparam logic [1:0] RS_2 = 2'd2;

  state_e     state_q, state_d;
  logic       out_q, out_d;
  logic [1:0] change_q, change_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    out_d    = 1'b0;
    change_d = RS_0;

    // An invalid coin code (2'b11) falls to the inner defaults: credit and state unchanged.
    case (state_q)
      S0: begin
        case (in)
          COIN_1:  state_d = S1;
          COIN_2:  state_d = S2;
          default: ;
        endcase
      end
      S1: begin
        case (in)
          COIN_NONE: begin
            state_d  = S0;
            change_d = RS_1;
          end
          COIN_1: state_d = S2;
          COIN_2: begin
            state_d = S0;
            out_d   = 1'b1;
          end
          default: ;
        endcase
      end
      S2: begin
        case (in)
          COIN_NONE: begin
            state_d  = S0;
            change_d = RS_2;
          end
          COIN_1: begin
            state_d = S0;
            out_d   = 1'b1;
          end
          COIN_2: begin
            state_d  = S0;
            out_d    = 1'b1;
            change_d = RS_1;
          end
          default: ;
        endcase
      end
      default: state_d = S0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S0;
      out_q    <= 1'b0;
      change_q <= RS_0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      change_q <= change_d;
    end
  end

  assign out    = out_q;
  assign change = change_q;

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine: expected {out, change} pushed to a
// scoreboard queue as each coin is driven, popped and compared after the edge.
module tb_vending_machine;

  logic       clk;
  logic       rst;
  logic [1:0] coin;
  logic       out;
  logic [1:0] change;

  int vectors     = 0;
  int miscompares = 0;

  logic [2:0] exp_q[$];

  vending_machine dut (
    .clk    (clk),
    .rst    (rst),
    .in     (coin),
    .out    (out),
    .change (change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  // Pop the oldest expectation and compare it with the outputs right now.
  task automatic compare(input string tag);
    logic [2:0] exp;
    if (exp_q.size() == 0) begin
      miscompares++;
      vectors++;
      $error("FAIL %s: scoreboard empty, got out=%b change=%b", tag, out, change);
    end else begin
      exp = exp_q.pop_front();
      vectors++;
      assert ({out, change} === exp)
      else begin
        miscompares++;
        $error("FAIL %s: got out=%b change=%b, required out=%b change=%b",
               tag, out, change, exp[2], exp[1:0]);
      end
    end
  endtask

  // Drive one coin for one edge and check the registered result 1 time unit later.
  task automatic step(input string tag, input logic [1:0] c,
                      input logic exp_out, input logic [1:0] exp_chg);
    coin = c;
    exp_q.push_back({exp_out, exp_chg});
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  // Check outputs immediately, without waiting for a clock edge.
  task automatic check_now(input string tag, input logic exp_out, input logic [1:0] exp_chg);
    exp_q.push_back({exp_out, exp_chg});
    compare(tag);
  endtask

  // Pulse rst well away from any rising edge (called at posedge + 1).
  task automatic pulse_reset();
    coin = 2'b00;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    coin = 2'b00;
    #2;
    check_now("reset_initial", 1'b0, 2'b00);

    // Coins presented while rst is held are ignored.
    coin = 2'b01;
    @(posedge clk);
    #1;
    check_now("reset_held_coin", 1'b0, 2'b00);
    #2 rst = 1'b0;
    step("reset_no_credit", 2'b00, 1'b0, 2'b00);

    // Rs 1 then cancel -> Rs 1 refund.
    step("t1_e1_coin1", 2'b01, 1'b0, 2'b00);
    step("t1_e2_refund1", 2'b00, 1'b0, 2'b01);
    step("t1_e3_idle", 2'b00, 1'b0, 2'b00);

    // Rs 2 + Rs 1 -> dispense; back-to-back coin accepted from S0.
    pulse_reset();
    step("t2_e1_coin2", 2'b10, 1'b0, 2'b00);
    step("t2_e2_dispense", 2'b01, 1'b1, 2'b00);
    step("t2_e3_pulse_end", 2'b00, 1'b0, 2'b00);
    step("t2_b2b_coin1", 2'b01, 1'b0, 2'b00);
    step("t2_b2b_refund1", 2'b00, 1'b0, 2'b01);

    // Rs 2 + Rs 2 -> dispense with Rs 1 change in the same cycle.
    pulse_reset();
    step("t3_e1_coin2", 2'b10, 1'b0, 2'b00);
    step("t3_e2_disp_chg", 2'b10, 1'b1, 2'b01);
    step("t3_e3_s0", 2'b00, 1'b0, 2'b00);

    // Three Rs 1 coins -> dispense, then Rs 2 and cancel -> Rs 2 refund.
    pulse_reset();
    step("t4_e1_coin1", 2'b01, 1'b0, 2'b00);
    step("t4_e2_coin1", 2'b01, 1'b0, 2'b00);
    step("t4_e3_dispense", 2'b01, 1'b1, 2'b00);
    step("t4_e4_coin2", 2'b10, 1'b0, 2'b00);
    step("t4_e5_refund2", 2'b00, 1'b0, 2'b10);
    step("t4_e6_idle", 2'b00, 1'b0, 2'b00);

    // Async reset in S2 discards credit: no refund afterwards.
    step("t5_coin2", 2'b10, 1'b0, 2'b00);
    coin = 2'b00;
    #2 rst = 1'b1;
    #1;
    check_now("t5_async_clear", 1'b0, 2'b00);
    #2 rst = 1'b0;
    step("t5_no_refund", 2'b00, 1'b0, 2'b00);

    // Async reset clears a live dispense/change pulse before the next edge.
    step("t5b_coin2", 2'b10, 1'b0, 2'b00);
    step("t5b_disp_chg", 2'b10, 1'b1, 2'b01);
    coin = 2'b00;
    #2 rst = 1'b1;
    #1;
    check_now("t5b_async_clear", 1'b0, 2'b00);
    #2 rst = 1'b0;
    step("t5b_idle", 2'b00, 1'b0, 2'b00);

    // Invalid code holds S1 credit; Rs 2 then completes exact Rs 3.
    step("t6_coin1", 2'b01, 1'b0, 2'b00);
    step("t6_invalid_a", 2'b11, 1'b0, 2'b00);
    step("t6_invalid_b", 2'b11, 1'b0, 2'b00);
    step("t6_dispense", 2'b10, 1'b1, 2'b00);
    step("t6_idle", 2'b00, 1'b0, 2'b00);

    // Invalid code from S2 holds credit; cancel refunds the full Rs 2.
    step("t7_coin2", 2'b10, 1'b0, 2'b00);
    step("t7_invalid", 2'b11, 1'b0, 2'b00);
    step("t7_refund2", 2'b00, 1'b0, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vending_machine.md
Name: vending_machine

Overview:
- Single-product coin vending controller. Item price is Rs 3; accepts Rs 1 and Rs 2 coins, one coin per clock.
- Dispenses the item and returns change, or refunds a partial credit when the customer stops inserting coins.
- Sits between the coin-acceptor front end (encoded coin bus) and the dispense/change actuators.
- Mealy-style decision logic with registered outputs.

Parameters:
- none. Price (Rs 3) and coin encodings are fixed.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  2  coin bus, sampled each rising edge: 2'b00 no coin, 2'b01 Rs 1, 2'b10 Rs 2, 2'b11 invalid.
- out  output  1  dispense pulse; 1 for exactly one clock after a completing edge.
- change  output  2  change/refund amount in Rs, binary (2'b00 = 0, 2'b01 = Rs 1, 2'b10 = Rs 2). Valid in the same cycle as the transaction result.

Behaviour:
- One clock; reset is asynchronous and active-high: rst high forces state S0, out=0, change=2'b00 immediately, independent of clk. Held while rst=1.
- States (credit held):
  - S0 = Rs 0
  - S1 = Rs 1
  - S2 = Rs 2
  - 2-bit state encoding; the fourth code recovers to S0 with outputs 0.
- Each rising edge with rst=0: next state, out and change are computed from the current state and in, then registered. Outputs reflect the edge just taken and hold until the next edge (one-cycle latency, one-cycle pulse).
- Transition table (current state, in -> next state, out, change):
  - S0, 00 -> S0, 0, 00
  - S0, 01 -> S1, 0, 00
  - S0, 10 -> S2, 0, 00
  - S1, 00 -> S0, 0, 01 (refund Rs 1; no coin means cancel)
  - S1, 01 -> S2, 0, 00
  - S1, 10 -> S0, 1, 00 (exact Rs 3)
  - S2, 00 -> S0, 0, 10 (refund Rs 2)
  - S2, 01 -> S0, 1, 00
  - S2, 10 -> S0, 1, 01 (Rs 4, change Rs 1)
- in=11 (invalid): state unchanged, out=0, change=00. No credit is taken.
- out=1 and a nonzero change can assert in the same cycle (S2 + Rs 2 only).
- A refund always returns the full held credit. Credit never exceeds Rs 2 between edges.
- Back-to-back purchases are allowed: a new coin on the edge after dispense is accepted from S0.
- Reset mid-transaction discards the held credit with no refund; outputs clear at once.
- in is assumed stable around the rising edge. No synchronizer is provided.

Test Plan:
- Reset, then in=01 for one edge, then in=00: edge 1 -> S1, out=0, change=00; edge 2 -> out=0, change=01; edge 3 -> out=0, change=00.
- Reset, then in=10, then in=01: edge 2 -> out=1, change=00; next edge with in=00 -> out=0, change=00, state S0.
- Reset, then in=10, then in=10: edge 2 -> out=1, change=01 in the same cycle; back to S0.
- Reset, then in=01, 01, 01: out=1, change=00 on edge 3. Then in=10, 00: change=10 refund, out=0.
- Assert rst asynchronously between edges while in S2: out and change go to 0 before the next edge. After release, in=00 gives no refund.
- From S1, apply in=11 for two edges: state stays S1, outputs 0. Then in=10 -> out=1, change=00.
